// File: rtl/sum_disp_pkg.sv
// Shared definitions for the adder-result display controller: FSM encoding,
// BCD/segment widths and the active-low seven-segment code table.
package sum_disp_pkg;

  localparam int BIN_W      = 9;
  localparam int DIGIT_W    = 4;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = BCD_DIGITS * DIGIT_W;
  localparam int SEG_W      = 7;
  localparam int AN_W       = 4;
  localparam int ITER_W     = 4;
  localparam int LAST_ITER  = BIN_W - 1;

  typedef enum logic [0:0] {
    STATE_IDLE    = 1'b0,
    STATE_CONVERT = 1'b1
  } state_e;

  // Plain-vector aliases of the enum so legacy code can hold state in a logic register
  localparam logic [0:0] ST_IDLE    = STATE_IDLE;
  localparam logic [0:0] ST_CONVERT = STATE_CONVERT;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Segment order abcdefg, a in the MSB, active-low
  localparam logic [SEG_W-1:0] SEG_CODES [10] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100
  };

  function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal
// codes turn every segment off.
module bcd_to_seg7
  import sum_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_CODES[digit];
    end
  end

endmodule

// File: rtl/sum_display_ctrl.sv
// Captures a 9-bit adder result, converts it to BCD with a sequential
// double-dabble, and time-multiplexes the digits onto a 4-digit display.
module sum_display_ctrl
  import sum_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  result,
  input  logic              load,
  output logic              busy,
  output logic [SEG_W-1:0]  seg,
  output logic [AN_W-1:0]   an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [0:0]          state;
  logic [ITER_W-1:0]   iter;
  logic [BIN_W-1:0]    bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_next;
  logic [BIN_W-1:0]    bin_next;

  logic [DIGIT_W-1:0]  disp_units;
  logic [DIGIT_W-1:0]  disp_tens;
  logic [DIGIT_W-1:0]  disp_hundreds;

  logic [RW-1:0]       refresh_cnt;
  logic [1:0]          scan_idx;
  logic [DIGIT_W-1:0]  digit_sel;
  logic                digit_blank;
  logic [SEG_W-1:0]    digit_seg;

  assign busy = (state == ST_CONVERT);

  // One double-dabble step: correct each nibble, then shift {bcd, bin} left
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      bcd_adj[d*DIGIT_W +: DIGIT_W] = add3_if_ge5(bcd_q[d*DIGIT_W +: DIGIT_W]);
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_next = {bin_q[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      iter          <= '0;
      bin_q         <= '0;
      bcd_q         <= '0;
      disp_units    <= '0;
      disp_tens     <= '0;
      disp_hundreds <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin_q <= result;
            bcd_q <= '0;
            iter  <= '0;
            state <= ST_CONVERT;
          end
        end
        default: begin
          bin_q <= bin_next;
          bcd_q <= bcd_next;
          iter  <= iter + 1'b1;
          // Display updates only on the final shift, so it never shows a partial value
          if (iter == ITER_W'(LAST_ITER)) begin
            disp_units    <= bcd_next[0*DIGIT_W +: DIGIT_W];
            disp_tens     <= bcd_next[1*DIGIT_W +: DIGIT_W];
            disp_hundreds <= bcd_next[2*DIGIT_W +: DIGIT_W];
            state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Free-running refresh divider; its wrap is the scan-advance enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    digit_sel   = '0;
    digit_blank = 1'b1;
    case (scan_idx)
      2'd0: begin
        digit_sel   = disp_units;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_sel   = disp_tens;
        digit_blank = (disp_hundreds == '0) && (disp_tens == '0);
      end
      2'd2: begin
        digit_sel   = disp_hundreds;
        digit_blank = (disp_hundreds == '0);
      end
      default: begin
        digit_sel   = '0;
        digit_blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg7 u_seg (
    .digit (digit_sel),
    .seg   (digit_seg)
  );

  always_comb begin
    seg = digit_seg;
    an  = ~(4'b0001 << scan_idx);
    if (digit_blank) begin
      seg = SEG_BLANK;
      an  = 4'b1111;
    end
  end

endmodule

// File: tb/tb_sum_display_ctrl.sv
// Directed bench for sum_display_ctrl with a 4-cycle refresh divider;
// table of results with hand-derived per-slot an/seg patterns plus corner sequences.
module tb_sum_display_ctrl;

  logic       clk;
  logic       rst_n;
  logic [8:0] result;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  typedef struct {
    logic [8:0]      result;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs [7];

  sum_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .result (result),
    .load   (load),
    .busy   (busy),
    .seg    (seg),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference scan position: rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] r);
    result = r;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Count busy over the 12 negedges following the capture edge
  task automatic checkBusy(input string name);
    int highs = 0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (busy === 1'b1) highs++;
    end
    checkOutput(name, 9'(highs), 9'd9);
  endtask

  task automatic checkSlot(input string name, input int slot,
                           input logic [3:0] expAn, input logic [6:0] expSeg);
    bit found = 0;
    for (int t = 0; t < 64 && !found; t++) begin
      @(negedge clk);
      if (((edges / 4) % 4) == slot) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: slot %0d never reached", name, slot);
    end else begin
      checkOutput({name, ".an"}, 9'(an), 9'(expAn));
      checkOutput({name, ".seg"}, 9'(seg), 9'(expSeg));
    end
  endtask

  initial begin
    vecs[0] = '{result: 9'd255,
                an:  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b1111111, 7'b0010010, 7'b0100100, 7'b0100100}};
    vecs[1] = '{result: 9'd7,
                an:  {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
    vecs[2] = '{result: 9'd40,
                an:  {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                seg: {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001}};
    vecs[3] = '{result: 9'd0,
                an:  {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    vecs[4] = '{result: 9'd99,
                an:  {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                seg: {7'b1111111, 7'b1111111, 7'b0000100, 7'b0000100}};
    vecs[5] = '{result: 9'd300,
                an:  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b1111111, 7'b0000110, 7'b0000001, 7'b0000001}};
    vecs[6] = '{result: 9'd511,
                an:  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b1111111, 7'b0100100, 7'b1001111, 7'b1001111}};

    rst_n  = 1'b0;
    load   = 1'b0;
    result = 9'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 9'(busy), 9'd0);
    checkOutput("reset.an", 9'(an), 9'b000001110);
    checkOutput("reset.seg", 9'(seg), 9'b000000001);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      checkSlot($sformatf("idle.slot%0d", s), s,
                (s == 0) ? 4'b1110 : 4'b1111,
                (s == 0) ? 7'b0000001 : 7'b1111111);
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].result);
      checkBusy($sformatf("v%0d.busy", i));
      for (int s = 0; s < 4; s++) begin
        checkSlot($sformatf("v%0d.slot%0d", i, s), s, vecs[i].an[s], vecs[i].seg[s]);
      end
    end

    // Second load during conversion must be dropped; result change alone must not show
    @(negedge clk);
    applyStimulus(9'd511);
    repeat (3) @(negedge clk);
    result = 9'd7;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    checkOutput("ovl.busy_n4", 9'(busy), 9'd1);
    repeat (4) @(negedge clk);
    checkOutput("ovl.busy_n8", 9'(busy), 9'd1);
    @(negedge clk);
    checkOutput("ovl.busy_n9", 9'(busy), 9'd0);
    checkSlot("ovl.slot0", 0, 4'b1110, 7'b1001111);
    checkSlot("ovl.slot1", 1, 4'b1101, 7'b1001111);
    checkSlot("ovl.slot2", 2, 4'b1011, 7'b0100100);
    checkSlot("ovl.slot3", 3, 4'b1111, 7'b1111111);

    // Consecutive loads in IDLE: only the first starts; busy still lasts 9 cycles
    @(negedge clk);
    result = 9'd7;
    load   = 1'b1;
    @(negedge clk);
    result = 9'd300;
    @(negedge clk);
    load   = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("dbl.busy_n8", 9'(busy), 9'd1);
    @(negedge clk);
    checkOutput("dbl.busy_n9", 9'(busy), 9'd0);
    checkSlot("dbl.slot0", 0, 4'b1110, 7'b0001111);
    checkSlot("dbl.slot2", 2, 4'b1111, 7'b1111111);

    // Reset in the middle of a conversion
    @(negedge clk);
    applyStimulus(9'd100);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.busy", 9'(busy), 9'd0);
    checkOutput("rstmid.an", 9'(an), 9'b000001110);
    checkOutput("rstmid.seg", 9'(seg), 9'b000000001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstmid.idle_busy", 9'(busy), 9'd0);
    checkSlot("rstmid.slot0", 0, 4'b1110, 7'b0000001);
    checkSlot("rstmid.slot1", 1, 4'b1111, 7'b1111111);
    checkSlot("rstmid.slot2", 2, 4'b1111, 7'b1111111);

    // 40 on display: tens slot recurs with a 16-cycle scan period
    @(negedge clk);
    applyStimulus(9'd40);
    checkBusy("p40.busy");
    checkSlot("p40.slot1", 1, 4'b1101, 7'b1001100);
    repeat (16) @(negedge clk);
    checkOutput("p40.period_an", 9'(an), 9'b000001101);
    checkOutput("p40.period_seg", 9'(seg), 9'b001001100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_display_ctrl.md
SUM_DISPLAY_CTRL -- requirements
Module: sum_display_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles each digit stays lit (legal >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: result  input  9  unsigned adder result {carry, sum[7:0]}, range 0..511.
REQ-005 Port: load  input  1  one-cycle strobe: capture result and start conversion.
REQ-006 Port: busy  output  1  high while binary-to-BCD conversion runs.
REQ-007 Port: seg  output  7  active-low segments, seg[6]=a .. seg[0]=g.
REQ-008 Port: an  output  4  active-low digit enables, an[0]=units .. an[3]=thousands.

Function
REQ-009 FSM states IDLE and CONVERT only; reset enters IDLE.
REQ-010 IDLE with load=1 at edge k: result captured into shift register, BCD scratch cleared, iteration counter=0, state CONVERT.
REQ-011 CONVERT: each edge applies add-3 to every BCD nibble >= 5, then shifts {bcd, bin} left one bit; counter increments.
REQ-012 On the edge where counter=8 (edge k+9): hundreds/tens/units display registers written atomically from final BCD, state returns to IDLE.
REQ-013 busy = (state==CONVERT); high exactly 9 cycles, edges k+1..k+9.
REQ-014 load while busy ignored; no queuing; conversion in flight unaffected.
REQ-015 load asserted in consecutive IDLE cycles: only the one sampled in IDLE starts a conversion.
REQ-016 Display registers hold the last completed conversion; a change on result without load never alters the display.
REQ-017 Refresh counter counts 0..REFRESH_DIV-1 continuously, wraps to 0; on wrap, scan index advances 0->1->2->3->0.
REQ-018 an = one-hot-low of scan index, unless that digit is blanked, then an=4'b1111 and seg=7'b1111111.
REQ-019 Digit 3 always blanked (max 511). Leading-zero blanking: hundreds blanked if 0; tens blanked if hundreds=0 and tens=0; units never blanked.
REQ-020 Segment codes (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-021 seg/an decoded combinationally from registered scan index and display registers; no glitch-free requirement beyond that.
REQ-022 Scanning continues uninterrupted during CONVERT.

Reset
REQ-023 rst_n low: state IDLE, busy=0, counters and scan index 0, display registers 0, shift/BCD scratch 0.
REQ-024 Outputs during/after reset: busy=0, an=4'b1110, seg=7'b0000001 (shows "0").
REQ-025 Reset mid-CONVERT aborts conversion; display returns to 0; first edge after deassertion behaves as IDLE.

Structure
REQ-026 Shared package sum_disp_pkg holds: state enum, SEG_BLANK constant, digit segment code table, BCD width constants.
REQ-027 One sub-module: bcd_to_seg7 (4-bit digit in, 7-bit active-low seg out, combinational; codes 10..15 give SEG_BLANK).
REQ-028 Conversion and scan logic stay in sum_display_ctrl; no second clock or derived clock; scan advances via enable only.

Verification (bench uses REFRESH_DIV=4)
REQ-029 Reset release, no load -> an=1110, seg=0000001 steady on digit 0; an=1111 for scan slots 1..3.
REQ-030 load with result=9'd255 -> busy high 9 cycles; then scan shows units seg=0100100, tens 0100100, hundreds 0010010, digit 3 off.
REQ-031 load result=9'd511, then load result=9'd7 on edge k+4 -> second load ignored; display 5/1/1.
REQ-032 load result=9'd7 after 511 shown -> hundreds and tens blanked (an=1111 in their slots), units seg=0001111.
REQ-033 load result=9'd100, assert rst_n=0 at edge k+5 -> busy=0 immediately, display returns to single "0".
REQ-034 load result=9'd40 -> tens seg=1001100, units seg=0000001 (units zero not blanked), hundreds blanked; scan period 16 cycles.
